// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports A/B, debug read, two write ports,
// busy-set request and the write-conflict flag.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ra_addr;
   logic [DATA_W-1:0] ra_data;
   logic              ra_busy;
   logic [ADDR_W-1:0] rb_addr;
   logic [DATA_W-1:0] rb_data;
   logic              rb_busy;
   logic              we0;
   logic [ADDR_W-1:0] waddr0;
   logic [DATA_W-1:0] wdata0;
   logic              we1;
   logic [ADDR_W-1:0] waddr1;
   logic [DATA_W-1:0] wdata1;
   logic              busy_set;
   logic [ADDR_W-1:0] busy_addr;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              wr_conflict;

   modport master (
      output ra_addr, rb_addr, dbg_addr,
      output we0, waddr0, wdata0, we1, waddr1, wdata1,
      output busy_set, busy_addr,
      input  ra_data, ra_busy, rb_data, rb_busy, dbg_data, wr_conflict
   );

   modport slave (
      input  ra_addr, rb_addr, dbg_addr,
      input  we0, waddr0, wdata0, we1, waddr1, wdata1,
      input  busy_set, busy_addr,
      output ra_data, ra_busy, rb_data, rb_busy, dbg_data, wr_conflict
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports with optional write
// bypass, a debug read port, two prioritised write ports and a busy scoreboard.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   regfile_mp_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic              wr_conflict_q;

   logic              zr_w0, zr_w1, zr_bs, zr_ra, zr_rb, zr_dbg;
   logic              wr0_en, wr1_en, conflict, bs_en;
   logic              hit0_a, hit1_a, hit0_b, hit1_b;
   logic              bs_a, bs_b;

   always_comb begin
      zr_w0  = ZERO_REG && (bus.waddr0 == '0);
      zr_w1  = ZERO_REG && (bus.waddr1 == '0);
      zr_bs  = ZERO_REG && (bus.busy_addr == '0);
      zr_ra  = ZERO_REG && (bus.ra_addr == '0);
      zr_rb  = ZERO_REG && (bus.rb_addr == '0);
      zr_dbg = ZERO_REG && (bus.dbg_addr == '0);

      // Port 1 wins a same-address collision; port 0 is dropped entirely.
      conflict = bus.we0 && bus.we1 && (bus.waddr0 == bus.waddr1) && !zr_w0;
      wr1_en   = bus.we1 && !zr_w1;
      wr0_en   = bus.we0 && !zr_w0 && !(bus.we1 && (bus.waddr1 == bus.waddr0));
      bs_en    = bus.busy_set && !zr_bs;

      hit0_a = bus.we0 && (bus.waddr0 == bus.ra_addr);
      hit1_a = bus.we1 && (bus.waddr1 == bus.ra_addr);
      hit0_b = bus.we0 && (bus.waddr0 == bus.rb_addr);
      hit1_b = bus.we1 && (bus.waddr1 == bus.rb_addr);
      bs_a   = bus.busy_set && (bus.busy_addr == bus.ra_addr);
      bs_b   = bus.busy_set && (bus.busy_addr == bus.rb_addr);
   end

   // A writeback retires the pending flag, but a fresh busy_set to the same
   // register in the same cycle represents a newer pending op and wins.
   always_comb begin
      busy_nxt = busy;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((bus.we0 && (bus.waddr0 == ADDR_W'(i))) ||
             (bus.we1 && (bus.waddr1 == ADDR_W'(i))))
            busy_nxt[i] = 1'b0;
         if (bs_en && (bus.busy_addr == ADDR_W'(i)))
            busy_nxt[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr0_en)
            mem[bus.waddr0] <= bus.wdata0;
         if (wr1_en)
            mem[bus.waddr1] <= bus.wdata1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy          <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         busy          <= busy_nxt;
         wr_conflict_q <= conflict;
      end
   end

   always_comb begin
      if (zr_ra)
         bus.ra_data = '0;
      else if (BYPASS && hit1_a)
         bus.ra_data = bus.wdata1;
      else if (BYPASS && hit0_a)
         bus.ra_data = bus.wdata0;
      else
         bus.ra_data = mem[bus.ra_addr];

      if (zr_rb)
         bus.rb_data = '0;
      else if (BYPASS && hit1_b)
         bus.rb_data = bus.wdata1;
      else if (BYPASS && hit0_b)
         bus.rb_data = bus.wdata0;
      else
         bus.rb_data = mem[bus.rb_addr];

      bus.dbg_data = zr_dbg ? '0 : mem[bus.dbg_addr];
   end

   always_comb begin
      if (zr_ra)
         bus.ra_busy = 1'b0;
      else if (BYPASS && (hit0_a || hit1_a) && !bs_a)
         bus.ra_busy = 1'b0;
      else
         bus.ra_busy = busy[bus.ra_addr];

      if (zr_rb)
         bus.rb_busy = 1'b0;
      else if (BYPASS && (hit0_b || hit1_b) && !bs_b)
         bus.rb_busy = 1'b0;
      else
         bus.rb_busy = busy[bus.rb_addr];

      bus.wr_conflict = wr_conflict_q;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default 32x32 instance and a 64-bit,
// 8-entry instance without zero register or bypass, driven in lockstep.
module tb_regfile_mp;
   logic clk;
   logic rst_n;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
   regfile_mp_if #(.DATA_W(64), .ADDR_W(3)) bus1 ();

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   regfile_mp #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [4:0]  ra, rb, dbg, wa0, wa1, ba;
      logic        we0, we1, bs;
      logic [63:0] wd0, wd1;
   } stim_t;

   typedef struct {
      logic [63:0] rad, rbd, dbgd;
      logic        rab, rbb, conf;
   } out_t;

   out_t q0[$];
   out_t q1[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic stim_valid = 1'b0;

   // Reference state: index 0 models u0 (32 regs), index 1 models u1 (8 regs).
   logic [63:0] m_mem  [2][32];
   logic        m_busy [2][32];
   logic        m_conf [2];

   function automatic bit zr(int d); return d == 0; endfunction
   function automatic bit bp(int d); return d == 0; endfunction
   function automatic logic [4:0] am(int d, logic [4:0] a);
      return (d == 0) ? a : (a & 5'd7);
   endfunction
   function automatic logic [63:0] dm(int d, logic [63:0] v);
      return (d == 0) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[d][i]  = '0;
            m_busy[d][i] = 1'b0;
         end
         m_conf[d] = 1'b0;
      end
   endfunction

   function automatic logic [63:0] port_val(int d, logic [4:0] a, stim_t s);
      if (zr(d) && a == 0) return '0;
      if (bp(d) && s.we1 && am(d, s.wa1) == a) return dm(d, s.wd1);
      if (bp(d) && s.we0 && am(d, s.wa0) == a) return dm(d, s.wd0);
      return m_mem[d][a];
   endfunction

   function automatic logic port_busy(int d, logic [4:0] a, stim_t s);
      bit hit;
      hit = (s.we0 && am(d, s.wa0) == a) || (s.we1 && am(d, s.wa1) == a);
      if (zr(d) && a == 0) return 1'b0;
      if (bp(d) && hit && !(s.bs && am(d, s.ba) == a)) return 1'b0;
      return m_busy[d][a];
   endfunction

   function automatic out_t model_out(int d, stim_t s);
      out_t o;
      o.rad  = port_val(d, am(d, s.ra), s);
      o.rbd  = port_val(d, am(d, s.rb), s);
      o.rab  = port_busy(d, am(d, s.ra), s);
      o.rbb  = port_busy(d, am(d, s.rb), s);
      o.dbgd = (zr(d) && am(d, s.dbg) == 0) ? '0 : m_mem[d][am(d, s.dbg)];
      o.conf = m_conf[d];
      return o;
   endfunction

   function automatic void model_step(int d, stim_t s);
      logic [4:0] a0, a1, ab;
      a0 = am(d, s.wa0);
      a1 = am(d, s.wa1);
      ab = am(d, s.ba);
      m_conf[d] = s.we0 && s.we1 && (a0 == a1) && !(zr(d) && a0 == 0);
      if (s.we0 && !(zr(d) && a0 == 0) && !(s.we1 && a1 == a0)) m_mem[d][a0] = dm(d, s.wd0);
      if (s.we1 && !(zr(d) && a1 == 0)) m_mem[d][a1] = dm(d, s.wd1);
      if (s.we0) m_busy[d][a0] = 1'b0;
      if (s.we1) m_busy[d][a1] = 1'b0;
      if (s.bs && !(zr(d) && ab == 0)) m_busy[d][ab] = 1'b1;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.rst_n = 1'b1;
      s.ra = '0; s.rb = '0; s.dbg = '0;
      s.wa0 = '0; s.wa1 = '0; s.ba = '0;
      s.we0 = 1'b0; s.we1 = 1'b0; s.bs = 1'b0;
      s.wd0 = '0; s.wd1 = '0;
      return s;
   endfunction

   function automatic logic [4:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) return 5'd0;
      if (r < 7) return 5'($urandom_range(1, 8));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic drive(input stim_t s);
      out_t e0, e1;
      @(posedge clk);
      #1;
      rst_n = s.rst_n;
      bus0.ra_addr = s.ra;       bus1.ra_addr = s.ra[2:0];
      bus0.rb_addr = s.rb;       bus1.rb_addr = s.rb[2:0];
      bus0.dbg_addr = s.dbg;     bus1.dbg_addr = s.dbg[2:0];
      bus0.we0 = s.we0;          bus1.we0 = s.we0;
      bus0.waddr0 = s.wa0;       bus1.waddr0 = s.wa0[2:0];
      bus0.wdata0 = s.wd0[31:0]; bus1.wdata0 = s.wd0;
      bus0.we1 = s.we1;          bus1.we1 = s.we1;
      bus0.waddr1 = s.wa1;       bus1.waddr1 = s.wa1[2:0];
      bus0.wdata1 = s.wd1[31:0]; bus1.wdata1 = s.wd1;
      bus0.busy_set = s.bs;      bus1.busy_set = s.bs;
      bus0.busy_addr = s.ba;     bus1.busy_addr = s.ba[2:0];
      if (!s.rst_n) model_reset();
      e0 = model_out(0, s);
      e1 = model_out(1, s);
      q0.push_back(e0);
      q1.push_back(e1);
      if (s.rst_n) begin
         model_step(0, s);
         model_step(1, s);
      end
      stim_valid = 1'b1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: outputs are stable mid-cycle; compare against the queued expectation.
   always @(negedge clk) begin
      out_t e;
      if (stim_valid) begin
         n_cmp++;
         if (q0.size() == 0 || q1.size() == 0) begin
            n_err++;
            $display("FAIL queue_underflow @%0t: got empty expected entry", $time);
         end else begin
            n_cmp--;
            e = q0.pop_front();
            chk("u0.ra_data",     64'(bus0.ra_data),  e.rad);
            chk("u0.rb_data",     64'(bus0.rb_data),  e.rbd);
            chk("u0.dbg_data",    64'(bus0.dbg_data), e.dbgd);
            chk("u0.ra_busy",     64'(bus0.ra_busy),  64'(e.rab));
            chk("u0.rb_busy",     64'(bus0.rb_busy),  64'(e.rbb));
            chk("u0.wr_conflict", 64'(bus0.wr_conflict), 64'(e.conf));
            e = q1.pop_front();
            chk("u1.ra_data",     bus1.ra_data,  e.rad);
            chk("u1.rb_data",     bus1.rb_data,  e.rbd);
            chk("u1.dbg_data",    bus1.dbg_data, e.dbgd);
            chk("u1.ra_busy",     64'(bus1.ra_busy),  64'(e.rab));
            chk("u1.rb_busy",     64'(bus1.rb_busy),  64'(e.rbb));
            chk("u1.wr_conflict", 64'(bus1.wr_conflict), 64'(e.conf));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      model_reset();
      rst_n = 1'b0;
      s = idle(); s.rst_n = 1'b0;
      drive(s);
      drive(s);

      // Write r5, then assert reset mid-cycle while reading it.
      s = idle(); s.we0 = 1'b1; s.wa0 = 5'd5; s.wd0 = 64'hDEAD_BEEF; s.bs = 1'b1; s.ba = 5'd6;
      drive(s);
      s = idle(); s.ra = 5'd5; s.rb = 5'd6; s.dbg = 5'd5;
      drive(s);
      s.rst_n = 1'b0;
      drive(s);
      s.rst_n = 1'b1;
      drive(s);

      // Dual write to distinct registers, then a same-address collision.
      s = idle(); s.we0 = 1'b1; s.wa0 = 5'd3; s.wd0 = 64'h11; s.we1 = 1'b1; s.wa1 = 5'd4; s.wd1 = 64'h22;
      drive(s);
      s = idle(); s.ra = 5'd3; s.rb = 5'd4;
      drive(s);
      s = idle(); s.we0 = 1'b1; s.wa0 = 5'd7; s.wd0 = 64'hAA; s.we1 = 1'b1; s.wa1 = 5'd7; s.wd1 = 64'hBB;
      drive(s);
      s = idle(); s.ra = 5'd7; s.dbg = 5'd7;
      drive(s);
      drive(s);

      // Zero register: both ports and busy_set target r0.
      s = idle(); s.we0 = 1'b1; s.wa0 = 5'd0; s.wd0 = 64'h1234; s.we1 = 1'b1; s.wa1 = 5'd0;
      s.wd1 = 64'h1234; s.bs = 1'b1; s.ba = 5'd0;
      drive(s);
      s = idle(); s.rb = 5'd0; s.ra = 5'd0;
      drive(s);
      drive(s);

      // Bypass on r9, single then dual write.
      s = idle(); s.ra = 5'd9; s.dbg = 5'd9; s.we0 = 1'b1; s.wa0 = 5'd9; s.wd0 = 64'h55;
      drive(s);
      s.wd0 = 64'h57; s.we1 = 1'b1; s.wa1 = 5'd9; s.wd1 = 64'h66;
      drive(s);
      s = idle(); s.ra = 5'd9; s.dbg = 5'd9;
      drive(s);

      // Busy scoreboard on r12 (r4 on the 8-entry instance).
      s = idle(); s.bs = 1'b1; s.ba = 5'd12;
      drive(s);
      s = idle(); s.ra = 5'd12;
      drive(s);
      s.we1 = 1'b1; s.wa1 = 5'd12; s.wd1 = 64'h77;
      drive(s);
      s = idle(); s.ra = 5'd12;
      drive(s);
      s.bs = 1'b1; s.ba = 5'd12; s.we0 = 1'b1; s.wa0 = 5'd12; s.wd0 = 64'h78;
      drive(s);
      s = idle(); s.ra = 5'd12;
      drive(s);

      // Full-width data at the top register; r0 must not alias r7.
      s = idle(); s.we1 = 1'b1; s.wa1 = 5'd7; s.wd1 = 64'hFFFF_FFFF_0000_0001;
      drive(s);
      s = idle(); s.ra = 5'd7; s.rb = 5'd0; s.dbg = 5'd7;
      drive(s);

      for (int n = 0; n < 2000; n++) begin
         s.rst_n = ($urandom_range(0, 99) != 0);
         s.ra  = pick_addr();
         s.rb  = pick_addr();
         s.dbg = pick_addr();
         s.we0 = $urandom_range(0, 1) != 0;
         s.we1 = $urandom_range(0, 2) == 0;
         s.bs  = $urandom_range(0, 3) == 0;
         s.wa0 = pick_addr();
         s.wa1 = ($urandom_range(0, 3) == 0) ? s.wa0 : pick_addr();
         s.ba  = ($urandom_range(0, 3) == 0) ? s.wa0 : pick_addr();
         s.wd0 = {$urandom, $urandom};
         s.wd1 = {$urandom, $urandom};
         drive(s);
      end

      @(posedge clk);
      #1;
      stim_valid = 1'b0;
      @(negedge clk);
      chk("queue_drain", 64'(q0.size() + q1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the CPU datapath, successor to the single-write-port 32x32 register file. It provides two combinational read ports plus a debug read port and two prioritised synchronous write ports. It adds a hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for long-latency writebacks. All storage clears on an asynchronous active-low reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: same-cycle write data forwarded to ra/rb read ports

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ra_addr  in  ADDR_W  read port A address
- ra_data  out  DATA_W  read port A data (combinational)
- ra_busy  out  1  read port A register has a pending write
- rb_addr  in  ADDR_W  read port B address
- rb_data  out  DATA_W  read port B data (combinational)
- rb_busy  out  1  read port B register has a pending write
- we0  in  1  write port 0 enable (ALU writeback)
- waddr0  in  ADDR_W  write port 0 address
- wdata0  in  DATA_W  write port 0 data
- we1  in  1  write port 1 enable (memory/long-latency writeback)
- waddr1  in  ADDR_W  write port 1 address
- wdata1  in  DATA_W  write port 1 data
- busy_set  in  1  mark busy_addr as pending
- busy_addr  in  ADDR_W  register to mark pending
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data; never bypassed
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address in the previous cycle

## Operation
- Storage: 2^ADDR_W x DATA_W array, plus a 2^ADDR_W busy-bit vector, plus the wr_conflict flop.
- Writes take effect on the rising clk edge when the port's we is high. Both ports may write different addresses in the same cycle.
- Same-address dual write: port 1 wins and port 0 is dropped. wr_conflict = 1 on the following cycle. Zero-register conflicts do not flag when ZERO_REG=1.
- ZERO_REG=1 covers reads, writes and busy for address 0:
  - Reads of address 0 on every port return 0.
  - Writes to address 0 are discarded.
  - busy_set to address 0 is ignored.
- Reads without bypass return array contents.
- BYPASS=1 applies to ra/rb only. If the read address matches an active write this cycle, that write's data is returned, with port 1 taking priority over port 0. Address 0 is excluded when ZERO_REG=1.
- Busy scoreboard:
  - busy_set sets busy[busy_addr] at the edge.
  - Any write (port 0 or port 1) to an address clears its busy bit at the edge.
  - A set and a write to the same address in the same cycle leave busy = 1, because the new pending operation wins.
- ra_busy/rb_busy = busy[addr]. With BYPASS=1 they are forced to 0 when a same-cycle write hits the address and there is no same-cycle busy_set to it.

## Timing
- Read latency: 0 cycles, combinational from address, array and bypass.
- Write-to-array latency: 1 edge. Non-bypassed reads and dbg_data show new data in the cycle after the write.
- Reset (rst_n low, asynchronous, held any duration):
  - All registers = 0, all busy = 0, wr_conflict = 0.
  - Hence ra_data/rb_data/dbg_data = 0 and ra_busy/rb_busy = 0 during reset, bypass aside.
- Writes and busy_set are ignored while rst_n is low. Reset deasserted mid-stream: the first edge with rst_n high performs normal updates.
- wr_conflict is high exactly one cycle per conflicting write cycle, and stays high across back-to-back conflicts.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 asynchronously between edges -> ra_data(r5)=0, all busy 0, wr_conflict 0, immediately and without waiting for a clock edge.
- Dual write: we0 r3=0x11, we1 r4=0x22 in one cycle -> next cycle r3=0x11, r4=0x22. Then both ports write r7 (0xAA on port 0, 0xBB on port 1) -> r7=0xBB, wr_conflict=1 for exactly one cycle.
- Zero register: write 0x1234 to r0 via both ports plus busy_set r0 -> r0 reads 0, rb_busy(r0)=0, wr_conflict=0. Repeat with ZERO_REG=0 -> r0=0x1234 (port 1 value), busy set, wr_conflict=1.
- Bypass: ra_addr=r9 with we0 r9=0x55 in the same cycle -> ra_data=0x55 and dbg_data(r9)=old value. Adding we1 r9=0x66 -> ra_data=0x66. With BYPASS=0, ra_data shows the old value until the next cycle.
- Scoreboard: busy_set r12 -> ra_busy=1 next cycle. we1 r12=0x77 -> busy cleared next cycle, and ra_busy=0 already in the write cycle (BYPASS=1). busy_set r12 together with we0 r12 in the same cycle -> busy stays 1.
- Parametrisation: DATA_W=64, ADDR_W=3 -> write 0xFFFF_FFFF_0000_0001 to r7 -> reads back exactly. Address wrap: 8 registers only, and no aliasing between r0 and r7.
